schoolbook_div: RTL and testbench

- Sequential shift-subtract (restoring) divider. It is the inverse of the library's shift-add schoolbook multiplier.
- Takes a 2N-bit dividend (for example, a product from the multiplier) and an N-bit divisor.
- Produces a 2N-bit quotient and an N-bit remainder, one quotient bit per cycle.
- Used for integer reduction and for round-trip checks of multiplier outputs.

---
 rtl/schoolbook_div_pkg.sv | 31 +++
 rtl/schoolbook_div_step.sv | 25 ++
 rtl/schoolbook_div.sv | 127 ++++++++++++
 tb/tb_schoolbook_div.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/schoolbook_div_pkg.sv
// Shared types and width helpers for the restoring shift-subtract divider.
package schoolbook_div_pkg;

    localparam int unsigned NDefault = 571;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    function automatic int unsigned dividend_w(input int unsigned n);
        return 2 * n;
    endfunction

    function automatic int unsigned quotient_w(input int unsigned n);
        return 2 * n;
    endfunction

    function automatic int unsigned remainder_w(input int unsigned n);
        return n;
    endfunction

    function automatic int unsigned count_w(input int unsigned n);
        return $clog2(2 * n + 1);
    endfunction

    localparam int unsigned DividendWDefault = dividend_w(NDefault);
    localparam int unsigned CountWDefault    = count_w(NDefault);

endpackage

// File: rtl/schoolbook_div_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract the divisor.
module schoolbook_div_step
    import schoolbook_div_pkg::*;
#(
    parameter int unsigned N = NDefault
) (
    input  logic [N-1:0] r_i,
    input  logic         d_msb_i,
    input  logic [N-1:0] b_i,
    output logic [N-1:0] r_o,
    output logic         bit_o
);

    logic [N:0]   t;
    logic [N-1:0] diff_lo;

    always_comb begin
        t       = {r_i, d_msb_i};
        bit_o   = (t >= {1'b0, b_i});
        // Only the low N bits of T-B are kept; when T >= B the result is < B, so it fits.
        diff_lo = t[N-1:0] - b_i;
        r_o     = bit_o ? diff_lo : t[N-1:0];
    end

endmodule

// File: rtl/schoolbook_div.sv
// Sequential restoring divider: 2N-bit dividend / N-bit divisor, one quotient bit per cycle.
module schoolbook_div
    import schoolbook_div_pkg::*;
#(
    parameter int unsigned N = NDefault
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [2*N-1:0] a,
    input  logic [N-1:0]   b,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] q,
    output logic [N-1:0]   r,
    output logic           dbz
);

    localparam int unsigned CW = count_w(N);
    localparam int unsigned DW = dividend_w(N);

    state_e          state_q, state_d;
    logic [CW-1:0]   count_q, count_d;
    logic [DW-1:0]   d_q, d_d;
    logic [N-1:0]    b_q, b_d;
    logic [N-1:0]    r_q, r_d;
    logic            zflag_q, zflag_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [DW-1:0]   quo_q, quo_d;
    logic [N-1:0]    rem_q, rem_d;
    logic            dbz_q, dbz_d;

    logic [N-1:0]    step_r;
    logic            step_bit;

    schoolbook_div_step #(
        .N (N)
    ) u_step (
        .r_i     (r_q),
        .d_msb_i (d_q[DW-1]),
        .b_i     (b_q),
        .r_o     (step_r),
        .bit_o   (step_bit)
    );

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        d_d     = d_q;
        b_d     = b_q;
        r_d     = r_q;
        zflag_d = zflag_q;
        done_d  = 1'b0;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;

        case (state_q)
            StIdle: begin
                if (start) begin
                    d_d     = a;
                    b_d     = b;
                    r_d     = '0;
                    count_d = '0;
                    zflag_d = (b == '0);
                    state_d = StRun;
                end
            end
            StRun: begin
                r_d     = step_r;
                d_d     = {d_q[DW-2:0], step_bit};
                count_d = count_q + 1'b1;
                if (count_q == CW'(DW - 1)) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                quo_d   = d_q;
                rem_d   = r_q;
                dbz_d   = zflag_q;
                done_d  = 1'b1;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            count_q <= '0;
            d_q     <= '0;
            b_q     <= '0;
            r_q     <= '0;
            zflag_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            quo_q   <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            d_q     <= d_d;
            b_q     <= b_d;
            r_q     <= r_d;
            zflag_q <= zflag_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign q    = quo_q;
    assign r    = rem_q;
    assign dbz  = dbz_q;

endmodule

// File: tb/tb_schoolbook_div.sv
// Scoreboard bench: small (N=8) directed/random instance plus default-width round-trip trials.
module tb_schoolbook_div;

    localparam int unsigned NS = 8;
    localparam int unsigned WS = 2 * NS;
    localparam int unsigned NL = 571;
    localparam int unsigned WL = 2 * NL;
    localparam int unsigned LTRIALS = 50;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc    = 0;
    int errors = 0;
    int checks = 0;

    logic          s_rst = 1'b1, s_start = 1'b0;
    logic [WS-1:0] s_a = '0;
    logic [NS-1:0] s_b = '0;
    logic          s_busy, s_done, s_dbz;
    logic [WS-1:0] s_q;
    logic [NS-1:0] s_r;

    logic          l_rst = 1'b1, l_start = 1'b0;
    logic [WL-1:0] l_a = '0;
    logic [NL-1:0] l_b = '0;
    logic          l_busy, l_done, l_dbz;
    logic [WL-1:0] l_q;
    logic [NL-1:0] l_r;

    schoolbook_div #(.N(NS)) u_small (
        .clk(clk), .rst(s_rst), .start(s_start), .a(s_a), .b(s_b),
        .busy(s_busy), .done(s_done), .q(s_q), .r(s_r), .dbz(s_dbz)
    );

    schoolbook_div #(.N(NL)) u_large (
        .clk(clk), .rst(l_rst), .start(l_start), .a(l_a), .b(l_b),
        .busy(l_busy), .done(l_done), .q(l_q), .r(l_r), .dbz(l_dbz)
    );

    typedef struct {
        logic [WS-1:0] q;
        logic [NS-1:0] r;
        logic          dbz;
        int            acc;
    } s_exp_t;

    typedef struct {
        logic [WL-1:0] q;
        logic [NL-1:0] r;
        logic          dbz;
        int            acc;
    } l_exp_t;

    s_exp_t s_sb[$];
    l_exp_t l_sb[$];

    // Reference result straight from integer division.
    function automatic s_exp_t s_ref(input logic [WS-1:0] a, input logic [NS-1:0] b, input int acc);
        s_exp_t        e;
        logic [WS-1:0] bw, rem;
        bw = {{NS{1'b0}}, b};
        e.acc = acc;
        if (b == '0) begin
            e.q   = '1;
            e.r   = a[NS-1:0];
            e.dbz = 1'b1;
        end else begin
            rem   = a % bw;
            e.q   = a / bw;
            e.r   = rem[NS-1:0];
            e.dbz = 1'b0;
        end
        return e;
    endfunction

    // Small-instance timing model: idle/busy window of 2N+1 cycles per accepted op.
    int            s_cnt = 0;
    logic          s_exp_done = 1'b0;
    logic [WS-1:0] s_hq = '0;
    logic [NS-1:0] s_hr = '0;
    logic          s_hdbz = 1'b0;

    always @(posedge clk) begin
        cyc = cyc + 1;
        s_exp_done = 1'b0;
        if (s_rst) begin
            s_cnt = 0;
            s_sb.delete();
            s_hq = '0;
            s_hr = '0;
            s_hdbz = 1'b0;
        end else if (s_cnt > 0) begin
            if (s_cnt == 1) begin
                s_exp_done = 1'b1;
                if (s_sb.size() > 0) begin
                    s_hq   = s_sb[0].q;
                    s_hr   = s_sb[0].r;
                    s_hdbz = s_sb[0].dbz;
                end
            end
            s_cnt = s_cnt - 1;
        end else if (s_start) begin
            s_sb.push_back(s_ref(s_a, s_b, cyc));
            s_cnt = 2 * NS + 1;
        end
    end

    always @(negedge clk) begin
        s_exp_t e;
        checks++;
        if (s_done !== s_exp_done) begin
            errors++;
            $display("FAIL s_done @%0d: got %b want %b", cyc, s_done, s_exp_done);
        end
        checks++;
        if (s_busy !== (s_cnt > 0)) begin
            errors++;
            $display("FAIL s_busy @%0d: got %b want %b", cyc, s_busy, (s_cnt > 0));
        end
        if (s_done === 1'b1) begin
            checks++;
            if (s_sb.size() == 0) begin
                errors++;
                $display("FAIL s_unexpected_done @%0d: got done=1 want no pending op", cyc);
            end else begin
                e = s_sb.pop_front();
                if (s_q !== e.q || s_r !== e.r || s_dbz !== e.dbz
                    || cyc - e.acc != 2 * NS + 1) begin
                    errors++;
                    $display("FAIL s_result @%0d: got q=%h r=%h dbz=%b lat=%0d want q=%h r=%h dbz=%b lat=%0d",
                             cyc, s_q, s_r, s_dbz, cyc - e.acc, e.q, e.r, e.dbz, 2 * NS + 1);
                end
            end
        end
        checks++;
        if (s_q !== s_hq || s_r !== s_hr || s_dbz !== s_hdbz) begin
            errors++;
            $display("FAIL s_hold @%0d: got q=%h r=%h dbz=%b want q=%h r=%h dbz=%b",
                     cyc, s_q, s_r, s_dbz, s_hq, s_hr, s_hdbz);
        end
    end

    always @(negedge clk) begin
        l_exp_t e;
        if (l_done === 1'b1) begin
            checks++;
            if (l_sb.size() == 0) begin
                errors++;
                $display("FAIL l_unexpected_done @%0d: got done=1 want no pending op", cyc);
            end else begin
                e = l_sb.pop_front();
                if (l_q !== e.q || l_r !== e.r || l_dbz !== e.dbz
                    || cyc - e.acc != 2 * NL + 1) begin
                    errors++;
                    $display("FAIL l_result @%0d: got q..%h r..%h dbz=%b lat=%0d want q..%h r..%h dbz=%b lat=%0d",
                             cyc, l_q[127:0], l_r[127:0], l_dbz, cyc - e.acc,
                             e.q[127:0], e.r[127:0], e.dbz, 2 * NL + 1);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic s_go(input logic [WS-1:0] a, input logic [NS-1:0] b);
        @(posedge clk);
        #2;
        s_a = a;
        s_b = b;
        s_start = 1'b1;
        @(posedge clk);
        #2;
        s_start = 1'b0;
    endtask

    function automatic logic [WL-1:0] rnd_bits(input int w);
        logic [WL-1:0] v, one;
        v = '0;
        one = 1;
        repeat ((WL + 31) / 32) v = {v[WL-33:0], 32'($urandom)};
        return v & ((one << w) - one);
    endfunction

    task automatic small_drv();
        repeat (2) @(posedge clk);
        #2 s_rst = 1'b0;
        @(negedge clk);
        chk("s_reset_q", 64'(s_q), 64'd0);
        chk("s_reset_busy", 64'({s_busy, s_done, s_dbz}), 64'd0);

        s_go(16'd1000, 8'd7);
        repeat (20) @(posedge clk);
        #2;
        chk("t1_q", 64'(s_q), 64'd142);
        chk("t1_r", 64'(s_r), 64'd6);
        chk("t1_dbz", 64'(s_dbz), 64'd0);

        s_go(16'hBEEF, 8'd0);
        repeat (20) @(posedge clk);
        #2;
        chk("dbz_q", 64'(s_q), 64'hFFFF);
        chk("dbz_r", 64'(s_r), 64'hEF);
        chk("dbz_flag", 64'(s_dbz), 64'd1);

        // Start pulses mid-run and during the final busy cycle must be dropped.
        s_go(16'd255, 8'd16);
        repeat (4) @(posedge clk);
        #2;
        s_a = 16'd9;
        s_b = 8'd3;
        s_start = 1'b1;
        @(posedge clk);
        #2 s_start = 1'b0;
        repeat (11) @(posedge clk);
        #2 s_start = 1'b1;
        @(posedge clk);
        #2 s_start = 1'b0;
        repeat (20) @(posedge clk);
        #2;
        chk("ign_q", 64'(s_q), 64'd15);
        chk("ign_r", 64'(s_r), 64'd15);

        s_go(16'd5000, 8'd13);
        repeat (4) @(posedge clk);
        #2 s_rst = 1'b1;
        @(posedge clk);
        #2 s_rst = 1'b0;
        chk("abort_q", 64'(s_q), 64'd0);
        s_go(16'd100, 8'd9);
        repeat (20) @(posedge clk);
        #2;
        chk("after_abort_q", 64'(s_q), 64'd11);
        chk("after_abort_r", 64'(s_r), 64'd1);

        // Back-to-back with start held and operands changing every cycle.
        @(posedge clk);
        #2 s_start = 1'b1;
        for (int i = 0; i < 100; i++) begin
            s_a = 16'($urandom);
            s_b = 8'($urandom_range(0, 255));
            @(posedge clk);
            #2;
        end
        s_start = 1'b0;
        repeat (20) @(posedge clk);

        for (int i = 0; i < 25; i++) begin
            s_go(16'($urandom), 8'($urandom_range(0, 255)));
            repeat (18) @(posedge clk);
        end
        repeat (3) @(posedge clk);
    endtask

    task automatic large_drv();
        logic [WL-1:0] x, y, z, av;
        l_exp_t        e;
        int            wy, wx;
        bit            got;
        repeat (2) @(posedge clk);
        #2 l_rst = 1'b0;
        @(negedge clk);
        checks++;
        if (l_q !== '0 || l_r !== '0 || l_dbz !== 1'b0 || l_busy !== 1'b0 || l_done !== 1'b0) begin
            errors++;
            $display("FAIL l_reset: got busy=%b done=%b dbz=%b want all zero", l_busy, l_done, l_dbz);
        end
        for (int t = 0; t < LTRIALS; t++) begin
            wy = $urandom_range(1, NL);
            y  = rnd_bits(wy);
            if (y == '0) y = 1;
            wx = $urandom_range(1, WL - wy);
            x  = rnd_bits(wx);
            z  = (t % 2 == 1) ? (rnd_bits(WL) % y) : '0;
            av = x * y + z;
            @(posedge clk);
            #2;
            l_a = av;
            l_b = y[NL-1:0];
            l_start = 1'b1;
            @(posedge clk);
            #1;
            e.q = x;
            e.r = z[NL-1:0];
            e.dbz = 1'b0;
            e.acc = cyc;
            l_sb.push_back(e);
            #1 l_start = 1'b0;
            got = 1'b0;
            for (int k = 0; k < 2 * NL + 10; k++) begin
                @(negedge clk);
                if (l_done === 1'b1) begin
                    got = 1'b1;
                    break;
                end
            end
            if (!got) begin
                errors++;
                checks++;
                $display("FAIL l_timeout trial %0d: got no done want done within %0d cycles",
                         t, 2 * NL + 10);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish want finish by time 2000000");
        $fatal(1, "watchdog expired");
    end

    initial begin
        fork
            small_drv();
            large_drv();
        join
        repeat (3) @(posedge clk);
        chk("s_sb_empty", 64'(s_sb.size()), 64'd0);
        chk("l_sb_empty", 64'(l_sb.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
